// File: rtl/serial_rx_if.sv
// Serial receive port bundle: the raw line into the receiver and the
// recovered byte with its completion/error strobes out of it.
interface serial_rx_if;
   logic       rxd_in;
   logic [7:0] rx_data;
   logic       rx_finish;
   logic       rx_error;

   modport master (
      input  rxd_in,
      output rx_data,
      output rx_finish,
      output rx_error
   );

   modport slave (
      output rxd_in,
      input  rx_data,
      input  rx_finish,
      input  rx_error
   );
endinterface

// File: rtl/serial_rx.sv
// UART receive front end: 16x oversampled 8N1 (or 8E1 with SERIAL_RX_PARITY_EN)
// frame recovery with majority-vote bit decisions and framing/parity error strobes.
module serial_rx #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 115200
) (
   input  logic        clk,
   input  logic        rst_n,
   serial_rx_if.master rx
);

   localparam int OS_DIV = CLK_FREQ / (BAUD * 16);
   localparam int OSW    = (OS_DIV > 2) ? $clog2(OS_DIV) : 1;

   generate
      if (OS_DIV < 2) begin : g_os_div_check
         $error("serial_rx: CLK_FREQ/(BAUD*16) must be at least 2");
      end
   endgenerate

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;
   localparam logic [2:0] ST_BREAK  = 3'd5;

   logic [2:0]     sync_reg;
   logic [2:0]     state_reg;
   logic [OSW-1:0] os_cnt_reg;
   logic [3:0]     samp_cnt_reg;
   logic [2:0]     bit_idx_reg;
   logic [7:0]     shift_reg;
   logic           s7_reg;
   logic           s8_reg;
   logic [7:0]     rx_data_reg;
   logic           rx_finish_reg;
   logic           rx_error_reg;

   logic       line;
   logic       fall;
   logic       tick;
   logic [3:0] samp_idx;
   logic       at_s9;
   logic       maj;
   logic       par_fault;

   assign line     = sync_reg[1];
   assign fall     = sync_reg[2] & ~sync_reg[1];
   assign tick     = (os_cnt_reg == OSW'(OS_DIV - 1));
   // Sample numbers count ticks from 1 so that samples 7..9 straddle mid-bit.
   assign samp_idx = samp_cnt_reg + 4'd1;
   assign at_s9    = tick && (samp_idx == 4'd9);
   assign maj      = (s7_reg & s8_reg) | (s7_reg & line) | (s8_reg & line);

`ifdef SERIAL_RX_PARITY_EN
   logic par_acc_reg;
   logic par_err_reg;

   assign par_fault = par_err_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_acc_reg <= 1'b0;
         par_err_reg <= 1'b0;
      end else if (at_s9) begin
         if (state_reg == ST_START) begin
            par_acc_reg <= 1'b0;
            par_err_reg <= 1'b0;
         end else if (state_reg == ST_DATA) begin
            par_acc_reg <= par_acc_reg ^ maj;
         end else if (state_reg == ST_PARITY) begin
            par_err_reg <= par_acc_reg ^ maj;
         end
      end
   end
`else
   assign par_fault = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg <= 3'b111;
      end else begin
         sync_reg <= {sync_reg[1:0], rx.rxd_in};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         os_cnt_reg    <= '0;
         samp_cnt_reg  <= 4'd0;
         bit_idx_reg   <= 3'd0;
         shift_reg     <= 8'h00;
         s7_reg        <= 1'b1;
         s8_reg        <= 1'b1;
         rx_data_reg   <= 8'h00;
         rx_finish_reg <= 1'b0;
         rx_error_reg  <= 1'b0;
      end else begin
         rx_finish_reg <= 1'b0;
         rx_error_reg  <= 1'b0;

         // Counters sit at zero while idle, so the start edge phase-aligns them.
         if (state_reg == ST_IDLE || state_reg == ST_BREAK) begin
            os_cnt_reg   <= '0;
            samp_cnt_reg <= 4'd0;
         end else if (tick) begin
            os_cnt_reg   <= '0;
            samp_cnt_reg <= samp_cnt_reg + 4'd1;
         end else begin
            os_cnt_reg   <= os_cnt_reg + OSW'(1);
         end

         if (tick && samp_idx == 4'd7) begin
            s7_reg <= line;
         end
         if (tick && samp_idx == 4'd8) begin
            s8_reg <= line;
         end

         case (state_reg)
            ST_IDLE: begin
               if (fall) begin
                  state_reg <= ST_START;
               end
            end
            ST_START: begin
               if (at_s9) begin
                  if (!maj) begin
                     state_reg   <= ST_DATA;
                     bit_idx_reg <= 3'd0;
                  end else begin
                     state_reg   <= ST_IDLE;
                  end
               end
            end
            ST_DATA: begin
               if (at_s9) begin
                  shift_reg[bit_idx_reg] <= maj;
                  if (bit_idx_reg == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                     state_reg <= ST_PARITY;
`else
                     state_reg <= ST_STOP;
`endif
                  end else begin
                     bit_idx_reg <= bit_idx_reg + 3'd1;
                  end
               end
            end
`ifdef SERIAL_RX_PARITY_EN
            ST_PARITY: begin
               if (at_s9) begin
                  state_reg <= ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               // Leaving at mid-stop lets a start edge right at stop end be caught.
               if (at_s9) begin
                  if (maj && !par_fault) begin
                     rx_data_reg   <= shift_reg;
                     rx_finish_reg <= 1'b1;
                     state_reg     <= ST_IDLE;
                  end else begin
                     rx_error_reg  <= 1'b1;
                     state_reg     <= maj ? ST_IDLE : ST_BREAK;
                  end
               end
            end
            ST_BREAK: begin
               if (line) begin
                  state_reg <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign rx.rx_data   = rx_data_reg;
   assign rx.rx_finish = rx_finish_reg;
   assign rx.rx_error  = rx_error_reg;

endmodule
